// File: rtl/lc3_ctrl_pkg.sv
// Shared encodings for the SLC-3 control unit: FSM states, opcodes and datapath mux selects.
package lc3_ctrl_pkg;

  // ADD and AND each have a register-operand and an immediate-operand state.
  // This lets SR2MUX be decoded from the state alone.
  typedef enum logic [4:0] {
    S_HALTED,
    S_18, S_33, S_35, S_32,
    S_01R, S_01I, S_05R, S_05I, S_09,
    S_00, S_22,
    S_12,
    S_04, S_21,
    S_06, S_25, S_27,
    S_07, S_23, S_16,
    S_P1, S_P2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [1:0] PC_PLUS1 = 2'b00;
  localparam logic [1:0] PC_BUS   = 2'b01;
  localparam logic [1:0] PC_ADDER = 2'b10;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/lc3_mem_wait_counter.sv
// Counts cycles spent in an SRAM access state.
// done flags the last cycle of a MEM_WAIT-long access.
module lc3_mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic done
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] cnt_q, cnt_d;

  assign done = start && (cnt_q == LAST);

  // The count returns to zero on the final access cycle.
  // This way every access state is entered with a cleared counter.
  always_comb begin
    cnt_d = (start && !done) ? cnt_q + 3'd1 : 3'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lc3_isdu.sv
// SLC-3 instruction sequence/decode unit.
// A Moore FSM whose control outputs depend only on the state and wait-counter registers.
module lc3_isdu
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t state_q, state_d;
  logic   mem_done;

  // JSRR is executed as JSR, so IR[11] has no effect.
  logic ir11_unused;
  assign ir11_unused = IR_11;

  lc3_mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk   (Clk),
    .Reset (Reset),
    .start (is_mem_wait_state(state_q)),
    .done  (mem_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_HALTED;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PC_PLUS1;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = A2_ZERO;
    ALUK       = ALUK_ADD;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;

    unique case (state_q)
      S_HALTED: if (Run) state_d = S_18;
      S_18: begin
        GatePC  = 1'b1;
        LD_MAR  = 1'b1;
        PCMUX   = PC_PLUS1;
        LD_PC   = 1'b1;
        state_d = S_33;
      end
      S_33: begin
        Mem_OE = 1'b0;
        if (mem_done) begin
          LD_MDR  = 1'b1;
          state_d = S_35;
        end
      end
      S_35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
        state_d = S_32;
      end
      S_32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD:   state_d = IR_5 ? S_01I : S_01R;
          OP_AND:   state_d = IR_5 ? S_05I : S_05R;
          OP_NOT:   state_d = S_09;
          OP_BR:    state_d = S_00;
          OP_JMP:   state_d = S_12;
          OP_JSR:   state_d = S_04;
          OP_LDR:   state_d = S_06;
          OP_STR:   state_d = S_07;
          OP_PAUSE: state_d = S_P1;
          default:  state_d = S_18;
        endcase
      end
      S_01R, S_01I, S_05R, S_05I, S_09: begin
        SR1MUX  = 1'b1;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        SR2MUX  = (state_q == S_01I) || (state_q == S_05I);
        ALUK    = (state_q == S_09) ? ALUK_NOT :
                  ((state_q == S_05R) || (state_q == S_05I)) ? ALUK_AND : ALUK_ADD;
        state_d = S_18;
      end
      S_00: state_d = BEN ? S_22 : S_18;
      S_22: begin
        ADDR2MUX = A2_OFF9;
        PCMUX    = PC_ADDER;
        LD_PC    = 1'b1;
        state_d  = S_18;
      end
      S_12: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        ADDR2MUX = A2_ZERO;
        PCMUX    = PC_ADDER;
        LD_PC    = 1'b1;
        state_d  = S_18;
      end
      S_04: begin
        GatePC  = 1'b1;
        DRMUX   = 1'b1;
        LD_REG  = 1'b1;
        state_d = S_21;
      end
      S_21: begin
        ADDR2MUX = A2_OFF11;
        PCMUX    = PC_ADDER;
        LD_PC    = 1'b1;
        state_d  = S_18;
      end
      S_06, S_07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = A2_OFF6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_d    = (state_q == S_06) ? S_25 : S_23;
      end
      S_25: begin
        Mem_OE = 1'b0;
        if (mem_done) begin
          LD_MDR  = 1'b1;
          state_d = S_27;
        end
      end
      S_27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_18;
      end
      S_23: begin
        ALUK    = ALUK_PASSA;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
        state_d = S_16;
      end
      S_16: begin
        Mem_WE = 1'b0;
        if (mem_done) state_d = S_18;
      end
      S_P1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = S_P2;
      end
      S_P2: if (!Continue) state_d = S_18;
      default: state_d = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_lc3_isdu.sv
// Self-checking bench for lc3_isdu: MEM_WAIT=2 and MEM_WAIT=3 instances.
// Each instance is compared cycle by cycle against microsequences built from the instruction rules.
module tb_lc3_isdu;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mem_oe, mem_we;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst    [2];
  logic       run    [2];
  logic       cont   [2];
  logic [3:0] opcode [2];
  logic       ir5    [2];
  logic       ir11   [2];
  logic       ben    [2];
  ctl_t       obs    [2];

  int   vectors = 0;
  int   miscompares = 0;
  ctl_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we;

    lc3_isdu #(.MEM_WAIT((g == 0) ? 2 : 3)) u_dut (
      .Clk(clk), .Reset(rst[g]), .Run(run[g]), .Continue(cont[g]),
      .Opcode(opcode[g]), .IR_5(ir5[g]), .IR_11(ir11[g]), .BEN(ben[g]),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
      .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
      .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
      .PCMUX(pcmux), .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux),
      .ADDR1MUX(addr1mux), .ADDR2MUX(addr2mux), .ALUK(aluk),
      .Mem_OE(mem_oe), .Mem_WE(mem_we)
    );

    assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                     gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux,
                     drmux, sr1mux, sr2mux, addr1mux, addr2mux, aluk, mem_oe, mem_we};
  end

  function automatic int mw_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch_first();
    ctl_t c = idle();
    c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00;
    return c;
  endfunction

  // Expected control words for one instruction, from its fetch up to the next fetch.
  task automatic build(input int d, input logic [3:0] op, input logic i5, input logic b);
    ctl_t c;
    int   mw = mw_of(d);
    exp_q.delete();
    exp_q.push_back(fetch_first());
    for (int k = 0; k < mw; k++) begin
      c = idle(); c.mem_oe = 1'b0; c.ld_mdr = (k == mw - 1); exp_q.push_back(c);
    end
    c = idle(); c.gate_mdr = 1'b1; c.ld_ir = 1'b1; exp_q.push_back(c);
    c = idle(); c.ld_ben = 1'b1; exp_q.push_back(c);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = idle(); c.sr1mux = 1'b1; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.aluk   = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        c.sr2mux = (op != 4'b1001) && i5;
        exp_q.push_back(c);
      end
      4'b0000: begin
        exp_q.push_back(idle());
        if (b) begin
          c = idle(); c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; exp_q.push_back(c);
        end
      end
      4'b1100: begin
        c = idle(); c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b00;
        c.pcmux = 2'b10; c.ld_pc = 1'b1; exp_q.push_back(c);
      end
      4'b0100: begin
        c = idle(); c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; exp_q.push_back(c);
        c = idle(); c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1; exp_q.push_back(c);
      end
      4'b0110, 4'b0111: begin
        c = idle(); c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1; exp_q.push_back(c);
        if (op == 4'b0110) begin
          for (int k = 0; k < mw; k++) begin
            c = idle(); c.mem_oe = 1'b0; c.ld_mdr = (k == mw - 1); exp_q.push_back(c);
          end
          c = idle(); c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; exp_q.push_back(c);
        end else begin
          c = idle(); c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; exp_q.push_back(c);
          for (int k = 0; k < mw; k++) begin
            c = idle(); c.mem_we = 1'b0; exp_q.push_back(c);
          end
        end
      end
      4'b1101: begin
        c = idle(); c.ld_led = 1'b1; exp_q.push_back(c);
        exp_q.push_back(idle());
      end
      default: ;
    endcase
  endtask

  // Checks the first 'limit' steps (all steps when limit < 0), one per falling edge.
  // Run toggles at random to show it is ignored once execution has started.
  task automatic run_seq(input int d, input logic [3:0] op, input logic i5, input logic b,
                         input logic cont_pre, input int limit, input string tag);
    int n;
    build(d, op, i5, b);
    opcode[d] = op; ir5[d] = i5; ben[d] = b; cont[d] = cont_pre;
    ir11[d] = 1'($urandom_range(0, 1));
    n = (limit < 0 || limit > exp_q.size()) ? exp_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      run[d] = 1'($urandom_range(0, 1));
      vectors++;
      if (obs[d] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s dut%0d op=%b step %0d: got %h expected %h", tag, d, op, i, obs[d], exp_q[i]);
      end
      if (op == 4'b1101 && cont_pre && i == exp_q.size() - 1) cont[d] = 1'b0;
      @(negedge clk);
    end
    run[d] = 1'b0;
  endtask

  task automatic check_now(input int d, input ctl_t e, input string tag);
    vectors++;
    if (obs[d] !== e) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h", tag, d, obs[d], e);
    end
  endtask

  task automatic start(input int d);
    run[d] = 1'b1;
    @(negedge clk);
    run[d] = 1'b0;
  endtask

  task automatic test_reset(input int d);
    rst[d] = 1'b1; run[d] = 1'b1; cont[d] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_now(d, idle(), "reset_state");
    end
    run[d] = 1'b0; rst[d] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_now(d, idle(), "halted_hold");
    end
  endtask

  task automatic test_add_imm();
    run_seq(0, 4'b0001, 1'b1, 1'b0, 1'b0, -1, "add_imm");
    check_now(0, fetch_first(), "add_imm_return");
  endtask

  task automatic test_branch();
    run_seq(0, 4'b0000, 1'b0, 1'b0, 1'b0, -1, "br_not_taken");
    run_seq(0, 4'b0000, 1'b0, 1'b1, 1'b0, -1, "br_taken");
    check_now(0, fetch_first(), "br_return");
  endtask

  task automatic test_jsr_jmp_nop();
    run_seq(0, 4'b0100, 1'b0, 1'b0, 1'b0, -1, "jsr");
    run_seq(0, 4'b1100, 1'b1, 1'b1, 1'b0, -1, "jmp");
    run_seq(0, 4'b1010, 1'b0, 1'b0, 1'b0, -1, "nop");
    check_now(0, fetch_first(), "nop_return");
  endtask

  task automatic test_pause();
    ctl_t p1 = idle();
    p1.ld_led = 1'b1;
    run_seq(0, 4'b1101, 1'b0, 1'b0, 1'b0, 4 + mw_of(0), "pause_fetch");
    for (int k = 0; k < 11; k++) begin
      check_now(0, p1, "pause_p1_hold");
      if (k < 10) @(negedge clk);
    end
    cont[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_now(0, idle(), "pause_p2_hold");
    end
    cont[0] = 1'b0;
    @(negedge clk);
    check_now(0, fetch_first(), "pause_release");
    run_seq(0, 4'b1101, 1'b0, 1'b0, 1'b1, -1, "pause_cont_high");
    check_now(0, fetch_first(), "pause_cont_return");
  endtask

  task automatic test_reset_mid_write();
    ctl_t s16 = idle();
    s16.mem_we = 1'b0;
    run_seq(0, 4'b0111, 1'b0, 1'b0, 1'b0, 4 + mw_of(0) + 2, "str_pre");
    check_now(0, s16, "str_s16_entry");
    #2 rst[0] = 1'b1;
    #1 check_now(0, idle(), "reset_async_we");
    @(negedge clk);
    check_now(0, idle(), "reset_hold");
    rst[0] = 1'b0;
    @(negedge clk);
    check_now(0, idle(), "reset_to_halted");
    start(0);
    run_seq(0, 4'b0111, 1'b0, 1'b0, 1'b0, -1, "str_after_reset");
    check_now(0, fetch_first(), "str_return");
  endtask

  task automatic test_mem_wait3();
    run_seq(1, 4'b0110, 1'b0, 1'b0, 1'b0, -1, "ldr_wait3");
    run_seq(1, 4'b0111, 1'b1, 1'b0, 1'b0, -1, "str_wait3");
    run_seq(1, 4'b0101, 1'b0, 1'b0, 1'b0, -1, "and_reg_wait3");
    check_now(1, fetch_first(), "wait3_return");
  endtask

  task automatic test_random(input int d, input int count);
    logic [3:0] op;
    for (int n = 0; n < count; n++) begin
      op = 4'($urandom_range(0, 15));
      run_seq(d, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b1, -1, "random");
    end
    check_now(d, fetch_first(), "random_return");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; run[d] = 1'b0; cont[d] = 1'b0;
      opcode[d] = '0; ir5[d] = 1'b0; ir11[d] = 1'b0; ben[d] = 1'b0;
    end
    @(negedge clk);

    test_reset(0);
    start(0);
    test_add_imm();
    test_branch();
    test_jsr_jmp_nop();
    test_pause();
    test_reset_mid_write();
    test_random(0, 60);
    rst[0] = 1'b1;

    test_reset(1);
    start(1);
    test_mem_wait3();
    test_random(1, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
